// File: rtl/osd_rect_writer.sv
// Rectangle draw engine: turns solid/outline rectangle commands into a stream
// of 32-bit, 8-pixel word writes for the OSD bitmap RAM.
module osd_rect_writer #(
  parameter int C_ADDR_WIDTH = 16,
  parameter int C_DEPTH      = 32768,
  parameter int C_DIM_WIDTH  = 12
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_DIM_WIDTH-1:0]  cmd_x,
  input  logic [C_DIM_WIDTH-1:0]  cmd_y,
  input  logic [C_DIM_WIDTH-1:0]  cmd_w,
  input  logic [C_DIM_WIDTH-1:0]  cmd_h,
  input  logic [C_DIM_WIDTH-1:0]  cmd_stride,
  input  logic [3:0]              cmd_fg,
  input  logic [3:0]              cmd_bg,
  input  logic                    cmd_mode,
  input  logic                    wr_ready,
  output logic [C_ADDR_WIDTH-1:0] osd_waddr,
  output logic [31:0]             osd_wdata,
  output logic                    osd_wreq,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int CW = 2 * C_DIM_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [C_DIM_WIDTH-1:0]  x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d, stride_q, stride_d;
  logic [3:0]              fg_q, fg_d, bg_q, bg_d;
  logic                    mode_q, mode_d;
  logic [C_ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [C_DIM_WIDTH-1:0]  col_q, col_d, row_q, row_d;
  logic                    err_q, err_d;
  logic                    wreq_q, wreq_d;
  logic [C_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [CW-1:0]           last_addr;
  logic                    row_fits, in_range;
  logic [C_ADDR_WIDTH-1:0] start_addr;
  logic                    last_col, last_row;

  // Outline: first/last rows are solid; inner rows carry fg only at the outer
  // pixel of the leftmost and rightmost words (both when the rectangle is one word wide).
  function automatic logic [31:0] word_data(input logic mode, input logic [3:0] fg,
                                            input logic [3:0] bg,
                                            input logic [C_DIM_WIDTH-1:0] row,
                                            input logic [C_DIM_WIDTH-1:0] col,
                                            input logic [C_DIM_WIDTH-1:0] w,
                                            input logic [C_DIM_WIDTH-1:0] h);
    logic [31:0] d;
    if (!mode || row == '0 || row == h - C_DIM_WIDTH'(1)) begin
      d = {8{fg}};
    end else begin
      d = {8{bg}};
      if (col == '0) d[3:0] = fg;
      if (col == w - C_DIM_WIDTH'(1)) d[31:28] = fg;
    end
    return d;
  endfunction

  always_comb begin
    row_fits   = (CW'(x_q) + CW'(w_q)) <= CW'(stride_q);
    last_addr  = (CW'(y_q) + CW'(h_q) - CW'(1)) * CW'(stride_q) + CW'(x_q) + CW'(w_q) - CW'(1);
    in_range   = last_addr < CW'(C_DEPTH);
    start_addr = C_ADDR_WIDTH'(y_q) * C_ADDR_WIDTH'(stride_q) + C_ADDR_WIDTH'(x_q);
    last_col   = col_q == w_q - C_DIM_WIDTH'(1);
    last_row   = row_q == h_q - C_DIM_WIDTH'(1);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    stride_d   = stride_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    mode_d     = mode_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    err_d      = err_q;
    wreq_d     = wreq_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x_d      = cmd_x;
          y_d      = cmd_y;
          w_d      = cmd_w;
          h_d      = cmd_h;
          stride_d = cmd_stride;
          fg_d     = cmd_fg;
          bg_d     = cmd_bg;
          mode_d   = cmd_mode;
          err_d    = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_q == '0 || h_q == '0) begin
          state_d = S_FIN;
        end else if (!row_fits || !in_range) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          row_base_d = start_addr;
          col_d      = '0;
          row_d      = '0;
          waddr_d    = start_addr;
          wdata_d    = word_data(mode_q, fg_q, bg_q, '0, '0, w_q, h_q);
          wreq_d     = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // Address advances incrementally; the only multiply lives in CHECK.
        if (wr_ready) begin
          if (!last_col) begin
            col_d   = col_q + C_DIM_WIDTH'(1);
            waddr_d = waddr_q + C_ADDR_WIDTH'(1);
            wdata_d = word_data(mode_q, fg_q, bg_q, row_q, col_d, w_q, h_q);
          end else if (!last_row) begin
            col_d      = '0;
            row_d      = row_q + C_DIM_WIDTH'(1);
            row_base_d = row_base_q + C_ADDR_WIDTH'(stride_q);
            waddr_d    = row_base_d;
            wdata_d    = word_data(mode_q, fg_q, bg_q, row_d, '0, w_q, h_q);
          end else begin
            wreq_d  = 1'b0;
            state_d = S_FIN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      wreq_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wreq_q  <= wreq_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk_in) begin
    x_q        <= x_d;
    y_q        <= y_d;
    w_q        <= w_d;
    h_q        <= h_d;
    stride_q   <= stride_d;
    fg_q       <= fg_d;
    bg_q       <= bg_d;
    mode_q     <= mode_d;
    row_base_q <= row_base_d;
    col_q      <= col_d;
    row_q      <= row_d;
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_FIN;
  assign err       = (state_q == S_FIN) && err_q;
  assign osd_wreq  = wreq_q;
  assign osd_waddr = waddr_q;
  assign osd_wdata = wdata_q;

endmodule

// File: tb/tb_osd_rect_writer.sv
// Bench for osd_rect_writer: directed vector table, backpressure and reset
// sequences, and randomized commands against a word-list reference model.
module tb_osd_rect_writer;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_x, cmd_y, cmd_w, cmd_h, cmd_stride;
  logic [3:0]  cmd_fg, cmd_bg;
  logic        cmd_mode;
  logic        wr_ready;
  logic [15:0] osd_waddr;
  logic [31:0] osd_wdata;
  logic        osd_wreq;
  logic        busy, done, err;

  osd_rect_writer dut (
    .clk_in(clk_in), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_stride(cmd_stride),
    .cmd_fg(cmd_fg), .cmd_bg(cmd_bg), .cmd_mode(cmd_mode), .wr_ready(wr_ready),
    .osd_waddr(osd_waddr), .osd_wdata(osd_wdata), .osd_wreq(osd_wreq),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x; int y; int w; int h; int s; int fg; int bg; int mode;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          err;
    int          done_off;
    int          p1_idx; int p1_addr; logic [31:0] p1_data;
    int          p2_idx; int p2_addr; logic [31:0] p2_data;
  } vec_t;

  int          m_addr[$];
  logic [31:0] m_data[$];
  int          m_err;
  int          a_addr[$];
  logic [31:0] a_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: enumerate the rectangle's words directly from its geometry.
  function automatic void model(input cmd_t c);
    int nib[8];
    logic [31:0] d;
    bit edge_row;
    m_addr.delete();
    m_data.delete();
    m_err = 0;
    if (c.w == 0 || c.h == 0) return;
    if (c.x + c.w > c.s || (c.y + c.h - 1) * c.s + c.x + c.w - 1 >= 32768) begin
      m_err = 1;
      return;
    end
    for (int r = 0; r < c.h; r++) begin
      for (int k = 0; k < c.w; k++) begin
        edge_row = (c.mode == 0) || (r == 0) || (r == c.h - 1);
        for (int n = 0; n < 8; n++) nib[n] = edge_row ? c.fg : c.bg;
        if (!edge_row && k == 0) nib[0] = c.fg;
        if (!edge_row && k == c.w - 1) nib[7] = c.fg;
        d = '0;
        for (int n = 0; n < 8; n++) d = d | (32'(nib[n]) << (4 * n));
        m_addr.push_back((c.y + r) * c.s + c.x + k);
        m_data.push_back(d);
      end
    end
  endfunction

  task automatic drive_cmd(input cmd_t c);
    cmd_x      = c.x[11:0];
    cmd_y      = c.y[11:0];
    cmd_w      = c.w[11:0];
    cmd_h      = c.h[11:0];
    cmd_stride = c.s[11:0];
    cmd_fg     = c.fg[3:0];
    cmd_bg     = c.bg[3:0];
    cmd_mode   = c.mode[0];
    cmd_valid  = 1'b1;
  endtask

  // rmode: 0 = sink always ready, 1 = random ready, 2 = fixed stall pattern.
  task automatic run_cmd(input cmd_t c, input int rmode, input string tag,
                         output int acc, output int dcyc, output int derr);
    bit          pat [0:6];
    bit          stall;
    logic [15:0] paddr;
    logic [31:0] pdata;
    int          last;
    int          idx;
    logic        dbusy;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    a_addr.delete();
    a_data.delete();
    drive_cmd(c);
    acc = -1; dcyc = -1; derr = 0; last = -1; stall = 0; dbusy = 0;
    paddr = '0; pdata = '0;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk_in);
    end
    if (acc < 0) begin
      chk({tag, " accept"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_in);
      cmd_valid = 1'b0;
      idx = cyc - acc - 2;
      case (rmode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ($urandom_range(0, 2) != 0);
        default: wr_ready = (idx >= 0 && idx < 7) ? pat[idx] : 1'b1;
      endcase
      if (stall) begin
        chk({tag, " stall wreq"}, osd_wreq, 1);
        chk({tag, " stall addr"}, osd_waddr, paddr);
        chk({tag, " stall data"}, osd_wdata, pdata);
      end
      if (done) begin
        dcyc  = cyc;
        derr  = err;
        dbusy = busy;
        break;
      end
      if (osd_wreq) begin
        if (wr_ready) begin
          a_addr.push_back(int'(osd_waddr));
          a_data.push_back(osd_wdata);
          last  = cyc;
          stall = 0;
        end else begin
          stall = 1;
          paddr = osd_waddr;
          pdata = osd_wdata;
        end
      end else begin
        stall = 0;
      end
    end
    if (dcyc < 0) begin
      chk({tag, " done timeout"}, 0, 1);
      return;
    end
    model(c);
    chk({tag, " nwrites"}, a_addr.size(), m_addr.size());
    for (int i = 0; i < a_addr.size() && i < m_addr.size(); i++) begin
      chk({tag, " addr"}, a_addr[i], m_addr[i]);
      chk({tag, " data"}, a_data[i], m_data[i]);
    end
    chk({tag, " err"}, derr, m_err);
    chk({tag, " done time"}, dcyc, (m_addr.size() > 0) ? last + 1 : acc + 2);
    chk({tag, " busy at done"}, dbusy, 1);
    @(negedge clk_in);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " ready after"}, cmd_ready, 1);
  endtask

  vec_t vecs[9];
  cmd_t c;
  int   acc, dcyc, derr, n;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; wr_ready = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_stride = '0;
    cmd_fg = '0; cmd_bg = '0; cmd_mode = 1'b0;

    vecs[0] = '{'{1, 3, 2, 2, 10, 5, 0, 0}, 0, 6, 1, 32, 32'h55555555, 3, 42, 32'h55555555};
    vecs[1] = '{'{0, 0, 3, 3, 3, 15, 0, 1}, 0, 11, 3, 3, 32'h0000000F, 5, 5, 32'hF0000000};
    vecs[2] = '{'{2, 1, 1, 4, 5, 2, 1, 1}, 0, 6, 1, 12, 32'h21111112, 3, 22, 32'h22222222};
    vecs[3] = '{'{8, 0, 4, 1, 10, 1, 0, 0}, 1, 2, -1, 0, 32'h0, -1, 0, 32'h0};
    vecs[4] = '{'{0, 0, 0, 3, 10, 1, 0, 0}, 0, 2, -1, 0, 32'h0, -1, 0, 32'h0};
    vecs[5] = '{'{0, 4095, 1, 1, 10, 1, 0, 0}, 1, 2, -1, 0, 32'h0, -1, 0, 32'h0};
    vecs[6] = '{'{0, 0, 3, 2, 3, 10, 3, 1}, 0, 8, 4, 4, 32'hAAAAAAAA, 0, 0, 32'hAAAAAAAA};
    vecs[7] = '{'{0, 4095, 8, 1, 8, 3, 0, 0}, 0, 10, 0, 32760, 32'h33333333, 7, 32767, 32'h33333333};
    vecs[8] = '{'{0, 4095, 8, 2, 8, 3, 0, 0}, 1, 2, -1, 0, 32'h0, -1, 0, 32'h0};

    repeat (3) @(negedge clk_in);
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset wreq", osd_wreq, 0);
    chk("reset waddr", osd_waddr, 0);
    chk("reset wdata", osd_wdata, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    @(negedge clk_in);
    chk("ready after reset", cmd_ready, 1);

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].c, 0, $sformatf("vec%0d", i), acc, dcyc, derr);
      chk($sformatf("vec%0d latency", i), dcyc - acc, vecs[i].done_off);
      chk($sformatf("vec%0d err pin", i), derr, vecs[i].err);
      if (vecs[i].p1_idx >= 0) begin
        if (vecs[i].p1_idx < a_addr.size() && vecs[i].p2_idx < a_addr.size()) begin
          chk($sformatf("vec%0d probe1 addr", i), a_addr[vecs[i].p1_idx], vecs[i].p1_addr);
          chk($sformatf("vec%0d probe1 data", i), a_data[vecs[i].p1_idx], vecs[i].p1_data);
          chk($sformatf("vec%0d probe2 addr", i), a_addr[vecs[i].p2_idx], vecs[i].p2_addr);
          chk($sformatf("vec%0d probe2 data", i), a_data[vecs[i].p2_idx], vecs[i].p2_data);
        end else begin
          chk($sformatf("vec%0d probe count", i), a_addr.size(), vecs[i].p2_idx + 1);
        end
      end
    end

    // Backpressure: sink pattern 1,0,0,1,0,1,1 puts the 4th transfer at accept+8.
    c = '{0, 0, 4, 1, 10, 9, 0, 0};
    run_cmd(c, 2, "bp", acc, dcyc, derr);
    chk("bp latency", dcyc - acc, 9);

    // Reset after the second transfer of a 3x3 fill.
    c = '{0, 0, 3, 3, 3, 7, 0, 0};
    drive_cmd(c);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      cmd_valid = 1'b0;
      wr_ready  = 1'b1;
      if (osd_wreq) n++;
      if (n == 2) break;
    end
    chk("rst seq two xfers", n, 2);
    chk("rst seq 2nd addr", osd_waddr, 1);
    @(negedge clk_in);
    wr_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk_in);
    chk("rst seq wreq", osd_wreq, 0);
    chk("rst seq busy", busy, 0);
    chk("rst seq done", done, 0);
    chk("rst seq ready in rst", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk_in);
    chk("rst seq ready after", cmd_ready, 1);
    c = '{1, 1, 2, 2, 5, 12, 4, 1};
    run_cmd(c, 0, "post rst", acc, dcyc, derr);
    chk("post rst latency", dcyc - acc, 6);

    for (int i = 0; i < 40; i++) begin
      c.s    = $urandom_range(1, 16);
      c.w    = $urandom_range(0, 6);
      c.h    = $urandom_range(0, 5);
      c.x    = $urandom_range(0, c.s);
      c.y    = ($urandom_range(0, 9) == 0) ? $urandom_range(4000, 4095) : $urandom_range(0, 50);
      c.fg   = $urandom_range(0, 15);
      c.bg   = $urandom_range(0, 15);
      c.mode = $urandom_range(0, 1);
      run_cmd(c, 1, $sformatf("rnd%0d", i), acc, dcyc, derr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osd_rect_writer.md
Name: osd_rect_writer

Overview:
- Command-driven bitmap generator upstream of the OSD overlay stage.
- Turns rectangle draw commands (solid fill or 1-pixel outline) into a stream of 32-bit word writes.
- The stream drives the OSD bitmap RAM write port (waddr/wdata/wreq).
- Bitmap format: 4 bits per pixel, 8 pixels per word; pixel k of a word sits in bits [4k+3:4k].
- Address space: linear words, word address = row*stride + word_column, increment 1 per word.

Parameters:
- C_ADDR_WIDTH, 16, width of osd_waddr.
- C_DEPTH, 32768, number of 32-bit words in the OSD RAM; valid addresses are 0..C_DEPTH-1.
- C_DIM_WIDTH, 12, width of all geometry fields in the command.

Ports:
- clk_in  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk_in.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  C_DIM_WIDTH  left edge, in words.
- cmd_y  in  C_DIM_WIDTH  top row.
- cmd_w  in  C_DIM_WIDTH  width, in words.
- cmd_h  in  C_DIM_WIDTH  height, in rows.
- cmd_stride  in  C_DIM_WIDTH  words per bitmap row.
- cmd_fg  in  4  foreground OSD code.
- cmd_bg  in  4  background OSD code (outline mode only).
- cmd_mode  in  1  0 = solid fill, 1 = outline.
- wr_ready  in  1  sink accepts the current write.
- osd_waddr  out  C_ADDR_WIDTH  word address.
- osd_wdata  out  32  8-pixel word.
- osd_wreq  out  1  write valid.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse when a command finishes.
- err  out  1  one-cycle pulse, coincident with done, when the command was rejected.

Behaviour:
- Reset values: cmd_ready=0 while rst is high, 1 in the first cycle after; busy=0, done=0, err=0, osd_wreq=0, osd_waddr=0, osd_wdata=0.
- States: IDLE, CHECK, RUN, FIN.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) latches all cmd_* fields, sets busy, and moves to CHECK.
  - cmd_ready=0 in every other state.
- CHECK (one cycle):
  - If w==0 or h==0: go to FIN, err=0, no writes.
  - If x+w > stride, or (y+h-1)*stride + x+w-1 >= C_DEPTH: go to FIN with err=1, no writes.
  - All check arithmetic uses 2*C_DIM_WIDTH+1 bits, so nothing overflows.
  - Otherwise: row_base = y*stride + x, col=0, row=0, go to RUN.
- RUN:
  - osd_wreq=1 with osd_waddr = row_base+col.
  - A word transfers when osd_wreq & wr_ready.
  - While wr_ready=0, osd_waddr and osd_wdata stay stable and osd_wreq stays high.
  - On transfer with col<w-1: col+1.
  - On transfer with col=w-1: col=0, row+1, row_base+=stride.
  - Transfer of the last word (row=h-1, col=w-1) moves to FIN; osd_wreq=0 in the next cycle.
  - Throughput: one word per cycle when wr_ready is held high.
  - osd_waddr is a registered output; the multiply is used only in CHECK, and the address is updated incrementally.
- Word data, solid fill: all 8 nibbles = fg.
- Word data, outline:
  - Row 0 and row h-1: all nibbles = fg.
  - Other rows: all nibbles = bg, except nibble 0 of col 0 and nibble 7 of col w-1, which are fg.
  - w==1: both nibbles 0 and 7 are fg in the same word.
  - h==1 or h==2: every word is all fg.
- FIN (one cycle): done=1, err as decided in CHECK, busy=0 from the next cycle, return to IDLE. The earliest next accept is the cycle after FIN.
- Latency: accept in cycle N → CHECK in N+1 → first osd_wreq in N+2. With wr_ready held high, done occurs in cycle N+2+w*h.
- rst in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - Any in-flight word is abandoned; already-transferred words are not undone.
- cmd_valid asserted while busy is ignored and not queued; the source holds the command until cmd_ready.

Test Plan:
- Solid fill: x=1, y=3, w=2, h=2, stride=10, fg=5, wr_ready=1 → writes to 31, 32, 41, 42 in consecutive cycles, each 0x55555555; done in cycle N+6; err=0.
- Outline: x=0, y=0, w=3, h=3, stride=3, fg=F, bg=0 →
  - addr 0–2: 0xFFFFFFFF.
  - addr 3: 0x0000000F; addr 4: 0x00000000; addr 5: 0xF0000000.
  - addr 6–8: 0xFFFFFFFF.
- Outline with w=1: h=4, fg=2, bg=1 → rows 1–2 data 0x21111112; rows 0 and 3 data 0x22222222.
- Backpressure: fill w=4, h=1, with wr_ready toggling 1,0,0,1,0,1,1 → osd_waddr/osd_wdata stable during stall cycles; exactly 4 transfers, in address order; done one cycle after the 4th transfer.
- Rejection:
  - x=8, w=4, stride=10 → done and err pulse together 2 cycles after accept; no osd_wreq.
  - w=0 → done pulse with err=0; no writes.
  - y=4095, h=1, stride=10 → err (address ≥ 32768).
- Reset mid-command: 3x3 fill, assert rst after the 2nd transfer → osd_wreq=0 and busy=0 in the next cycle; cmd_ready=1 one cycle after rst drops; a new command then runs normally from its own start address.
